pll_reset_seq: RTL and testbench

- Free-running sequencer for the iCE40 PLL wrapper.
- Drives the PLL's RESETB, qualifies its LOCK output and releases a clean system reset only after lock has been stable.
- Recovers from lock timeout and lock loss by re-pulsing the PLL; flags permanent failure after bounded retries.
- Clocked by the 48 MHz board input, which is valid before the PLL locks; downstream 24 MHz domains synchronise sys_resetn themselves.

---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/pll_reset_seq_sync_2ff.sv | 26 ++
 rtl/pll_reset_seq.sv | 128 ++++++++++++
 tb/tb_pll_reset_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the iCE40 PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4800;
  localparam int unsigned DEF_STABLE_CYCLES = 480;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  localparam int RETRY_W = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// Generic two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL RESETB driver, lock qualifier and system reset release with bounded retry.
// Optional PLL_SEQ_LOSS_CNT_EN adds loss_cnt and state_o observation ports.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_resetb,
  output logic               sys_resetn,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]         loss_cnt,
  output logic [2:0]         state_o
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (resetn),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_resetb_q, sys_resetn_q, fail_q;

  // restart outranks lock loss, which outranks the lock/timeout checks
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        PLL_RST: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = FAIL;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN:     if (!locked_s) state_d = PLL_RST;
        FAIL:    state_d = FAIL;
        default: state_d = PLL_RST;
      endcase
    end
    cnt_d = (restart || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      sys_resetn_q <= (state_d == RUN);
      fail_q       <= (state_d == FAIL);
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign sys_resetn = sys_resetn_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       run_loss;

  assign run_loss = !restart && (state_q == RUN) && !locked_s;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      loss_q <= '0;
    end else if (run_loss && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
  assign state_o  = state_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq (RST=4, TIMEOUT=20, STABLE=8, RETRY=2).
module tb_pll_reset_seq;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       fail;
  logic [3:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
  logic [2:0] state_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clkin = ~clkin;

  pll_reset_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2)
  ) dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_resetn (sys_resetn),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt),
    .state_o    (state_o)
`endif
  );

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Edges until pll_resetb equals lvl (bounded)
  task automatic until_resetb(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_resetb !== lvl && n < 200);
  endtask

  task automatic until_sys(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sys_resetn !== lvl && n < 200);
  endtask

  task automatic test_reset();
    resetn = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    tick(); tick();
    total++; if (pll_resetb !== 1'b0) begin bad++; $display("FAIL reset_pll_resetb got=%b exp=0", pll_resetb); end
    total++; if (sys_resetn !== 1'b0) begin bad++; $display("FAIL reset_sys_resetn got=%b exp=0", sys_resetn); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt); end
  endtask

  task automatic test_lock_normal();
    int n;
    resetn = 1'b1;
    until_resetb(1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL normal_rst_len got=%0d exp=4", n); end
    repeat (5) tick();
    pll_locked = 1'b1;
    // 2 sync edges, 1 edge into STABLE, 8 stable edges
    until_sys(1'b1, n);
    total++; if (n !== 11) begin bad++; $display("FAIL normal_release got=%0d exp=11", n); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL normal_retry got=%0d exp=0", retry_cnt); end
    total++; if (pll_resetb !== 1'b1) begin bad++; $display("FAIL normal_pll_resetb got=%b exp=1", pll_resetb); end
  endtask

  task automatic test_run_loss();
    int n;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    total++; if (sys_resetn !== 1'b1) begin bad++; $display("FAIL loss_early got=%b exp=1", sys_resetn); end
    until_sys(1'b0, n);
    n = n + 1;
    total++; if (n !== 3) begin bad++; $display("FAIL loss_latency got=%0d exp=3", n); end
    total++; if (pll_resetb !== 1'b0) begin bad++; $display("FAIL loss_pll_resetb got=%b exp=0", pll_resetb); end
    until_resetb(1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL loss_rst_len got=%0d exp=4", n); end
    until_sys(1'b1, n);
    total++; if (n !== 9) begin bad++; $display("FAIL loss_rerelease got=%0d exp=9", n); end
  endtask

  task automatic test_stable_glitch();
    int n;
    pll_locked = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n = 0;
    while (retry_cnt !== 4'd1 && n < 100) begin tick(); n++; end
    pll_locked = 1'b1;
    until_resetb(1'b1, n);
    tick();  // entry edge into STABLE, counter 0
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(); tick();  // lock-loss seen here, back to WAIT_LOCK
    total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL glitch_retry got=%0d exp=1", retry_cnt); end
    total++; if (sys_resetn !== 1'b0) begin bad++; $display("FAIL glitch_sys got=%b exp=0", sys_resetn); end
`ifdef PLL_SEQ_LOSS_CNT_EN
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL glitch_state got=%0d exp=1", state_o); end
`endif
    until_sys(1'b1, n);
    total++; if (n !== 9) begin bad++; $display("FAIL glitch_release got=%0d exp=9", n); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL glitch_retry_clr got=%0d exp=0", retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    int n;
    bit ok;
    pll_locked = 1'b0;
    until_resetb(1'b0, n);
    for (int i = 0; i < 3; i++) begin
      until_resetb(1'b1, n);
      total++; if (n !== 4) begin bad++; $display("FAIL to_rst_len%0d got=%0d exp=4", i, n); end
      until_resetb(1'b0, n);
      total++; if (n !== 20) begin bad++; $display("FAIL to_wait_len%0d got=%0d exp=20", i, n); end
      if (i < 2) begin
        total++; if (retry_cnt !== 4'(i + 1)) begin bad++; $display("FAIL to_retry%0d got=%0d exp=%0d", i, retry_cnt, i + 1); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL to_nofail%0d got=%b exp=0", i, fail); end
      end else begin
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL to_fail got=%b exp=1", fail); end
        total++; if (retry_cnt !== 4'd2) begin bad++; $display("FAIL to_retry_final got=%0d exp=2", retry_cnt); end
      end
    end
    ok = 1'b1;
    repeat (30) begin
      tick();
      if (pll_resetb !== 1'b0 || sys_resetn !== 1'b0 || fail !== 1'b1) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_hold got=%b%b%b exp=001", pll_resetb, sys_resetn, fail); end
  endtask

  task automatic test_restart_fail();
    int n;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL rs_fail got=%b exp=0", fail); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL rs_retry got=%0d exp=0", retry_cnt); end
    total++; if (pll_resetb !== 1'b0) begin bad++; $display("FAIL rs_pll_resetb got=%b exp=0", pll_resetb); end
    pll_locked = 1'b1;
    until_resetb(1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL rs_rst_len got=%0d exp=4", n); end
    until_sys(1'b1, n);
    total++; if (n !== 9) begin bad++; $display("FAIL rs_release got=%0d exp=9", n); end
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (retry_cnt !== 4'd1 && n < 100) begin tick(); n++; end
    until_resetb(1'b1, n);
    repeat (5) tick();
    total++; if (pll_resetb !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b exp=1", pll_resetb); end
    #2;
    resetn = 1'b0;
    #1;  // still well before the next clkin edge
    total++; if (pll_resetb !== 1'b0) begin bad++; $display("FAIL ar_pll_resetb got=%b exp=0", pll_resetb); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL ar_retry got=%0d exp=0", retry_cnt); end
    total++; if (sys_resetn !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL ar_sys_fail got=%b%b exp=00", sys_resetn, fail); end
    tick(); tick();
    resetn = 1'b1;
  endtask

`ifdef PLL_SEQ_LOSS_CNT_EN
  task automatic test_loss_cnt();
    int n;
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("FAIL lc_reset got=%0d exp=0", loss_cnt); end
    pll_locked = 1'b1;
    until_sys(1'b1, n);
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      until_sys(1'b0, n);
      until_sys(1'b1, n);
      if (i == 2) begin
        total++; if (loss_cnt !== 8'd3) begin bad++; $display("FAIL lc_three got=%0d exp=3", loss_cnt); end
      end
    end
    total++; if (loss_cnt !== 8'd255) begin bad++; $display("FAIL lc_sat got=%0d exp=255", loss_cnt); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (loss_cnt !== 8'd255) begin bad++; $display("FAIL lc_restart got=%0d exp=255", loss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_normal();
    test_run_loss();
    test_stable_glitch();
    test_timeout_fail();
    test_restart_fail();
    test_async_reset();
`ifdef PLL_SEQ_LOSS_CNT_EN
    test_loss_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
